// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD command arbiter: command codes, FSM states, id width.
package lcd_arb_pkg;

  localparam int unsigned ID_W = 1;

  typedef logic [2:0]      cmd_t;
  typedef logic [ID_W-1:0] id_t;

  localparam cmd_t CMD_WRITE = 3'd0;
  localparam cmd_t CMD_SHUP  = 3'd1;
  localparam cmd_t CMD_SHDN  = 3'd2;
  localparam cmd_t CMD_SHLT  = 3'd3;
  localparam cmd_t CMD_SHRT  = 3'd4;
  localparam cmd_t CMD_AVG   = 3'd5;
  localparam cmd_t CMD_MIRX  = 3'd6;
  localparam cmd_t CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_IDLE,
    FIN
  } state_t;

  function automatic logic is_write(input cmd_t c);
    return c == CMD_WRITE;
  endfunction

endpackage

// File: rtl/lcd_cmd_arbiter_if.sv
// Requester and LCD-controller handshake bundle for lcd_cmd_arbiter.
interface lcd_cmd_arbiter_if;
  import lcd_arb_pkg::*;

  logic req0_valid;
  cmd_t req0_cmd;
  logic req0_ready;
  logic req1_valid;
  cmd_t req1_cmd;
  logic req1_ready;
  logic cpl_valid;
  id_t  cpl_id;
  cmd_t lcd_cmd;
  logic lcd_cmd_valid;
  logic lcd_busy;
  logic lcd_done;
  logic arb_done;
  logic ack_err;

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
    input  req0_ready, req1_ready, cpl_valid, cpl_id, lcd_cmd, lcd_cmd_valid,
           arb_done, ack_err
  );

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
    output req0_ready, req1_ready, cpl_valid, cpl_id, lcd_cmd, lcd_cmd_valid,
           arb_done, ack_err
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small per-requester command FIFO with full/empty flags and synchronous flush.
module lcd_cmd_fifo
  import lcd_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        wr_en;
  logic        rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Two-requester arbiter for the single LCD controller command port.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module lcd_cmd_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACK_TO = 8
) (
  input logic              clk,
  input logic              reset,
  lcd_cmd_arbiter_if.slave arb
);

  localparam int unsigned CNT_W = $clog2(ACK_TO + 1);

  state_t           state;
  state_t           state_nx;
  cmd_t             head0;
  cmd_t             head1;
  cmd_t             cmd_q;
  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic             pop0;
  logic             pop1;
  logic             flush;
  logic             accepting;
  logic             ready0;
  logic             ready1;
  id_t              grant;
  id_t              owner_q;
  id_t              cpl_id_q;
  logic             wr_flag;
  logic             cpl_sent;
  logic             cpl_fire;
  logic             ack_fire;
  logic             cpl_valid_q;
  logic             arb_done_q;
  logic             ack_err_q;
  logic [CNT_W-1:0] ack_cnt;

  assign accepting = (state != INIT) && (state != FIN);
  assign ready0    = accepting && !full0;
  assign ready1    = accepting && !full1;
  assign flush     = (state == FIN);

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush),
    .push  (arb.req0_valid && ready0),
    .din   (arb.req0_cmd),
    .pop   (pop0),
    .dout  (head0),
    .full  (full0),
    .empty (empty0)
  );

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush),
    .push  (arb.req1_valid && ready1),
    .din   (arb.req1_cmd),
    .pop   (pop1),
    .dout  (head1),
    .full  (full1),
    .empty (empty1)
  );

`ifdef LCD_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = id_t'(empty0);
  end
`else
  id_t last_q;

  always_comb begin
    grant = id_t'(empty0);
    if (!empty0 && !empty1) grant = ~last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= id_t'(1);
    end else if (state == IDLE && state_nx == ISSUE) begin
      last_q <= grant;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    cpl_fire = 1'b0;
    ack_fire = 1'b0;
    pop0     = 1'b0;
    pop1     = 1'b0;
    case (state)
      INIT: if (!arb.lcd_busy) state_nx = IDLE;
      IDLE: begin
        if (arb.lcd_done) state_nx = FIN;
        else if ((!empty0 || !empty1) && !arb.lcd_busy) state_nx = ISSUE;
      end
      ISSUE: begin
        pop0     = (owner_q == id_t'(0));
        pop1     = (owner_q == id_t'(1));
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (arb.lcd_busy) begin
          state_nx = WAIT_IDLE;
        end else if (ack_cnt == CNT_W'(ACK_TO - 1)) begin
          cpl_fire = 1'b1;
          ack_fire = 1'b1;
          state_nx = (wr_flag || arb.lcd_done) ? FIN : IDLE;
        end
      end
      WAIT_IDLE: begin
        // A write completion may precede lcd_done; hold here without re-pulsing.
        if (!cpl_sent && !arb.lcd_busy) begin
          cpl_fire = 1'b1;
          if (arb.lcd_done) state_nx = FIN;
          else if (!wr_flag) state_nx = IDLE;
        end else if (cpl_sent && arb.lcd_done) begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = FIN;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      cmd_q       <= '0;
      owner_q     <= '0;
      wr_flag     <= 1'b0;
      cpl_sent    <= 1'b0;
      ack_cnt     <= '0;
      cpl_valid_q <= 1'b0;
      cpl_id_q    <= '0;
      arb_done_q  <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      cpl_valid_q <= cpl_fire;
      if (state == IDLE && state_nx == ISSUE) begin
        cmd_q   <= (grant == id_t'(1)) ? head1 : head0;
        owner_q <= grant;
      end
      if (state == ISSUE) begin
        wr_flag  <= is_write(cmd_q);
        ack_cnt  <= '0;
        cpl_sent <= 1'b0;
      end else begin
        if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
        if (cpl_fire) cpl_sent <= 1'b1;
      end
      if (cpl_fire) cpl_id_q <= owner_q;
      if (ack_fire) ack_err_q <= 1'b1;
      if (state_nx == FIN) arb_done_q <= 1'b1;
    end
  end

  assign arb.req0_ready    = ready0;
  assign arb.req1_ready    = ready1;
  assign arb.lcd_cmd       = cmd_q;
  assign arb.lcd_cmd_valid = (state == ISSUE);
  assign arb.cpl_valid     = cpl_valid_q;
  assign arb.cpl_id        = cpl_id_q;
  assign arb.arb_done      = arb_done_q;
  assign arb.ack_err       = ack_err_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed self-checking bench for lcd_cmd_arbiter with a small LCD controller model.
module tb_lcd_cmd_arbiter;
  import lcd_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_cmd_arbiter_if arb ();

  logic busy_m, done_m, busy_hold;
  int   busy_len;
  logic done_on_rel, noack_en;
  assign arb.lcd_busy = busy_m | busy_hold;
  assign arb.lcd_done = done_m;

  lcd_cmd_arbiter #(.DEPTH(4), .ACK_TO(8)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   issued_q[$];
  int   issue_cyc_q[$];
  int   cpl_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Controller model: busy rises the cycle after a strobe, falls busy_len cycles later.
  initial begin : lcd_model
    int  cnt;
    bit  pend;
    busy_m = 1'b0;
    done_m = 1'b0;
    cnt    = 0;
    pend   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (arb.cpl_valid) cpl_q.push_back(int'(arb.cpl_id));
      if (!reset) begin
        busy_m = 1'b0;
        done_m = 1'b0;
        cnt    = 0;
        pend   = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            busy_m = 1'b0;
            if (done_on_rel) done_m = 1'b1;
          end
        end
        if (pend) begin
          pend   = 1'b0;
          busy_m = 1'b1;
          cnt    = busy_len;
        end
        if (arb.lcd_cmd_valid) begin
          issued_q.push_back(int'(arb.lcd_cmd));
          issue_cyc_q.push_back(cyc);
          if (!(noack_en && arb.lcd_cmd == CMD_SHLT)) pend = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_reqs();
    arb.req0_valid = 1'b0;
    arb.req1_valid = 1'b0;
    arb.req0_cmd   = '0;
    arb.req1_cmd   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    tick(3);
    reset = 1'b1;
  endtask

  task automatic push2(input bit v0, input int c0, input bit v1, input int c1);
    arb.req0_valid = v0;
    arb.req0_cmd   = cmd_t'(c0);
    arb.req1_valid = v1;
    arb.req1_cmd   = cmd_t'(c1);
    @(negedge clk);
    arb.req0_valid = 1'b0;
    arb.req1_valid = 1'b0;
  endtask

  task automatic wait_issued(input string tag, input int n, input int budget);
    int k = 0;
    while (issued_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, issued_q.size(), n);
  endtask

  initial begin : stim
    int base, cbase, push_cyc;
    int exp_c[4];
    int exp_i[4];
    int ovf[5];
    int k;

    reset       = 1'b0;
    busy_hold   = 1'b1;
    busy_len    = 1;
    done_on_rel = 1'b0;
    noack_en    = 1'b0;
    clear_reqs();

    // Reset state and INIT hold-off while the image load keeps busy high
    tick(3);
    check("rst_rdy0", arb.req0_ready, 0);
    check("rst_rdy1", arb.req1_ready, 0);
    check("rst_cmd_valid", arb.lcd_cmd_valid, 0);
    check("rst_cpl_valid", arb.cpl_valid, 0);
    check("rst_arb_done", arb.arb_done, 0);
    check("rst_ack_err", arb.ack_err, 0);
    check("rst_lcd_cmd", arb.lcd_cmd, 0);
    reset = 1'b1;
    tick(70);
    check("init_rdy0", arb.req0_ready, 0);
    check("init_no_issue", issued_q.size(), 0);
    busy_hold = 1'b0;
    tick(2);
    check("idle_rdy0", arb.req0_ready, 1);
    check("idle_rdy1", arb.req1_ready, 1);

    // Requester 0 alone: 1,4,5
    base  = issued_q.size();
    cbase = cpl_q.size();
    push_cyc = cyc;
    push2(1, 1, 0, 0);
    push2(1, 4, 0, 0);
    push2(1, 5, 0, 0);
    wait_issued("seq_wait", base + 3, 60);
    tick(6);
    exp_c = '{1, 4, 5, 0};
    for (int i = 0; i < 3; i++) check($sformatf("seq_cmd%0d", i), issued_q[base + i], exp_c[i]);
    check("seq_latency", issue_cyc_q[base] - push_cyc, 2);
    check("seq_cpl_cnt", cpl_q.size() - cbase, 3);
    for (int i = 0; i < 3; i++) check($sformatf("seq_cpl_id%0d", i), cpl_q[cbase + i], 0);

    // Both requesters loaded with two commands each
    do_reset();
    tick(2);
    busy_hold = 1'b1;
    base  = issued_q.size();
    cbase = cpl_q.size();
    push2(1, 6, 1, 7);
    push2(1, 6, 1, 7);
    busy_hold = 1'b0;
    wait_issued("arb_wait", base + 4, 80);
    tick(6);
`ifdef LCD_ARB_FIXED_PRIO_EN
    exp_c = '{6, 6, 7, 7};
    exp_i = '{0, 0, 1, 1};
`else
    exp_c = '{6, 7, 6, 7};
    exp_i = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) check($sformatf("arb_cmd%0d", i), issued_q[base + i], exp_c[i]);
    check("arb_cpl_cnt", cpl_q.size() - cbase, 4);
    for (int i = 0; i < 4; i++) check($sformatf("arb_cpl_id%0d", i), cpl_q[cbase + i], exp_i[i]);

    // Overflow: five pushes into a depth-4 FIFO while the controller is busy
    busy_hold = 1'b1;
    base  = issued_q.size();
    ovf   = '{1, 2, 4, 5, 6};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ovf_rdy%0d", i), arb.req1_ready, (i < 4) ? 1 : 0);
      arb.req1_valid = 1'b1;
      arb.req1_cmd   = cmd_t'(ovf[i]);
      @(negedge clk);
    end
    arb.req1_valid = 1'b0;
    busy_hold = 1'b0;
    wait_issued("ovf_wait", base + 4, 80);
    tick(12);
    check("ovf_count", issued_q.size() - base, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_cmd%0d", i), issued_q[base + i], ovf[i]);

    // Unacknowledged command 3 times out; the next queued command still issues
    noack_en  = 1'b1;
    busy_hold = 1'b1;
    base  = issued_q.size();
    cbase = cpl_q.size();
    push2(1, 3, 0, 0);
    push2(1, 2, 0, 0);
    busy_hold = 1'b0;
    wait_issued("to_wait", base + 1, 20);
    tick(8);
    check("to_err_before", arb.ack_err, 0);
    tick(1);
    check("to_err_set", arb.ack_err, 1);
    check("to_cpl_pulse", arb.cpl_valid, 1);
    check("to_cpl_id", arb.cpl_id, 0);
    wait_issued("to_next_wait", base + 2, 20);
    check("to_next_cmd", issued_q[base + 1], 2);
    tick(6);
    check("to_cpl_cnt", cpl_q.size() - cbase, 2);
    check("to_cmd_hold", arb.lcd_cmd, 2);
    check("to_err_sticky", arb.ack_err, 1);
    noack_en = 1'b0;

    // Terminal write: long busy, then done; later commands never issue
    busy_len    = 64;
    done_on_rel = 1'b1;
    busy_hold   = 1'b1;
    base  = issued_q.size();
    cbase = cpl_q.size();
    push2(1, 0, 0, 0);
    push2(1, 6, 0, 0);
    busy_hold = 1'b0;
    wait_issued("wr_wait", base + 1, 20);
    check("wr_cmd", issued_q[base], 0);
    tick(30);
    check("wr_not_done", arb.arb_done, 0);
    check("wr_no_cpl", cpl_q.size() - cbase, 0);
    check("wr_rdy1_open", arb.req1_ready, 1);
    push2(0, 0, 1, 5);
    k = 0;
    while (!arb.arb_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wr_arb_done", arb.arb_done, 1);
    tick(10);
    check("wr_cpl_cnt", cpl_q.size() - cbase, 1);
    check("wr_cpl_id", cpl_q[cbase], 0);
    check("wr_issue_cnt", issued_q.size() - base, 1);
    check("fin_rdy0", arb.req0_ready, 0);
    check("fin_rdy1", arb.req1_ready, 0);

    // Mid-operation reset aborts the in-flight command silently
    busy_len    = 20;
    done_on_rel = 1'b0;
    do_reset();
    check("rr_arb_done", arb.arb_done, 0);
    check("rr_ack_err", arb.ack_err, 0);
    tick(2);
    base = issued_q.size();
    push2(1, 4, 0, 0);
    wait_issued("abort_wait", base + 1, 20);
    tick(5);
    cbase = cpl_q.size();
    reset = 1'b0;
    tick(3);
    check("abort_valid", arb.lcd_cmd_valid, 0);
    reset = 1'b1;
    tick(25);
    check("abort_no_cpl", cpl_q.size() - cbase, 0);
    check("abort_no_reissue", issued_q.size() - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
